// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit (master)
// and instruction memory (slave): in-order req/gnt issue, rvalid responses.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch front-end: owns the PC, issues credit-limited in-order requests, and
// buffers returned words with their PCs in a FWFT queue feeding IF/ID.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master imem,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    input  logic         stall,
    output logic         o_valid,
    output logic [31:0]  o_instruction,
    output logic [31:0]  o_pc
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_C = SUM_W'(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [31:0]      fetch_pc;
    logic [31:0]      tag_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] tag_wr_ptr;
    logic [PTR_W-1:0] tag_rd_ptr;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] inflight_nxt;
    logic [CNT_W-1:0] drop;

    logic [31:0]      q_pc   [QUEUE_DEPTH];
    logic [31:0]      q_data [QUEUE_DEPTH];
    logic [PTR_W-1:0] q_wr_ptr;
    logic [PTR_W-1:0] q_rd_ptr;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W-1:0] q_count_nxt;

    logic             issue;
    logic             resp;
    logic             push;
    logic             pop;
    logic [SUM_W-1:0] credits_used;

    // Queued words plus outstanding requests may never exceed the queue size,
    // so every response always has a slot waiting for it.
    assign credits_used  = SUM_W'(q_count) + SUM_W'(inflight);
    assign imem.imem_req = !rst && !redirect && (credits_used < DEPTH_C);
    assign imem.imem_addr = fetch_pc;

    assign issue = imem.imem_req && imem.imem_gnt;
    assign resp  = imem.imem_rvalid;
    assign push  = resp && !redirect && (drop == '0);

    assign o_valid       = (q_count != '0);
    assign pop           = o_valid && !stall;
    assign o_instruction = o_valid ? q_data[q_rd_ptr] : NOP_INSTR;
    assign o_pc          = o_valid ? q_pc[q_rd_ptr] : 32'h0;

    always_comb begin
        inflight_nxt = inflight;
        if (issue && !resp)
            inflight_nxt = inflight + CNT_ONE;
        else if (!issue && resp)
            inflight_nxt = inflight - CNT_ONE;
    end

    always_comb begin
        q_count_nxt = q_count;
        if (push && !pop)
            q_count_nxt = q_count + CNT_ONE;
        else if (pop && !push)
            q_count_nxt = q_count - CNT_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc   <= RESET_PC;
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
            inflight   <= '0;
            drop       <= '0;
            q_wr_ptr   <= '0;
            q_rd_ptr   <= '0;
            q_count    <= '0;
        end else begin
            if (redirect)
                fetch_pc <= redirect_pc & ~32'h3;
            else if (issue)
                fetch_pc <= fetch_pc + 32'd4;

            if (issue)
                tag_wr_ptr <= tag_wr_ptr + PTR_ONE;
            if (resp)
                tag_rd_ptr <= tag_rd_ptr + PTR_ONE;
            inflight <= inflight_nxt;

            // Everything still outstanding after this cycle belongs to the old path.
            if (redirect)
                drop <= inflight_nxt;
            else if (resp && (drop != '0))
                drop <= drop - CNT_ONE;

            if (redirect) begin
                q_wr_ptr <= '0;
                q_rd_ptr <= '0;
                q_count  <= '0;
            end else begin
                if (push)
                    q_wr_ptr <= q_wr_ptr + PTR_ONE;
                if (pop)
                    q_rd_ptr <= q_rd_ptr + PTR_ONE;
                q_count <= q_count_nxt;
            end
        end
    end

    // Storage only; validity is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (issue)
            tag_mem[tag_wr_ptr] <= fetch_pc;
        if (push) begin
            q_pc[q_wr_ptr]   <= tag_mem[tag_rd_ptr];
            q_data[q_wr_ptr] <= imem.imem_rdata;
        end
    end

    rvalid_needs_inflight: assert property (
        @(posedge clk) disable iff (rst) imem.imem_rvalid |-> (inflight != '0)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order latency-randomised memory model plus a word-level
// reference of the fetch stream (expected queue of {pc, word}).
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        o_valid;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;

  fetch_unit_if ifc ();

  fetch_unit #(
    .RESET_PC   (RESET_PC),
    .QUEUE_DEPTH(DEPTH),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem         (ifc),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .stall        (stall),
    .o_valid      (o_valid),
    .o_instruction(o_instruction),
    .o_pc         (o_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          ready;
    logic        stale;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } word_t;

  mreq_t       mq[$];   // requests accepted by memory, oldest first
  word_t       eq[$];   // words the fetch unit should be holding, head first
  logic [31:0] mpc;
  int          cyc = 0;
  int          last_ready = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;

  logic        obs_req, obs_valid, exp_req, exp_valid;
  logic [31:0] obs_addr, obs_pc, obs_instr, exp_addr, exp_pc, exp_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0] ^ 16'h5A01};
  endfunction

  task automatic clear_model();
    mq.delete();
    eq.delete();
    mpc = RESET_PC;
    last_ready = cyc;
  endtask

  task automatic restart();
    @(negedge clk);
    #2;
    rst = 1'b1;
    ifc.imem_gnt = 1'b0;
    ifc.imem_rvalid = 1'b0;
    redirect = 1'b0;
    stall = 1'b0;
    clear_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive inputs at the falling edge, sample, then advance the reference
  // to the state the next rising edge should produce.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc, input logic g);
    mreq_t m;
    word_t w;
    int    lat;
    int    r;
    @(negedge clk);
    stall = st;
    redirect = rd;
    redirect_pc = rpc;
    ifc.imem_gnt = g;
    if (mq.size() != 0 && mq[0].ready <= cyc) begin
      ifc.imem_rvalid = 1'b1;
      ifc.imem_rdata = mq[0].data;
    end else begin
      ifc.imem_rvalid = 1'b0;
      ifc.imem_rdata = $urandom;
    end
    #1;
    obs_req = ifc.imem_req;
    obs_addr = ifc.imem_addr;
    obs_valid = o_valid;
    obs_pc = o_pc;
    obs_instr = o_instruction;
    exp_valid = (eq.size() != 0);
    exp_pc = exp_valid ? eq[0].pc : 32'h0;
    exp_instr = exp_valid ? eq[0].data : NOP;
    exp_req = !rd && (eq.size() + mq.size() < DEPTH);
    exp_addr = mpc;
    if (rd) begin
      eq.delete();
      foreach (mq[i]) mq[i].stale = 1'b1;
      if (ifc.imem_rvalid) void'(mq.pop_front());
      mpc = rpc & ~32'h3;
    end else begin
      if (exp_valid && !st) void'(eq.pop_front());
      if (ifc.imem_rvalid) begin
        m = mq.pop_front();
        if (!m.stale) begin
          w.pc = m.pc;
          w.data = m.data;
          eq.push_back(w);
        end
      end
      if (exp_req && g) begin
        lat = $urandom_range(lat_hi, lat_lo);
        r = cyc + lat;
        if (r <= last_ready) r = last_ready + 1;
        last_ready = r;
        m.pc = mpc;
        m.data = mem_word(mpc);
        m.ready = r;
        m.stale = 1'b0;
        mq.push_back(m);
        mpc = mpc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ifc.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, expected 0", ifc.imem_req); end
    checks++; if (ifc.imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr: got %h, expected %h", ifc.imem_addr, RESET_PC); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", o_valid); end
    checks++; if (o_instruction !== NOP) begin errors++; $display("FAIL reset_instr: got %h, expected %h", o_instruction, NOP); end
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h, expected 0", o_pc); end
  endtask

  task automatic test_sequential_fetch();
    int          first_valid;
    logic [31:0] seen_pc[$];
    logic [31:0] seen_ins[$];
    first_valid = -1;
    restart();
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      if (obs_valid && first_valid < 0) first_valid = i;
      if (obs_valid) begin seen_pc.push_back(obs_pc); seen_ins.push_back(obs_instr); end
      checks++;
      if (obs_valid !== exp_valid || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
        errors++;
        $display("FAIL seq_out cyc %0d: got v=%b pc=%h ins=%h, expected v=%b pc=%h ins=%h",
                 i, obs_valid, obs_pc, obs_instr, exp_valid, exp_pc, exp_instr);
      end
    end
    // Release cycle, grant cycle, response cycle, then the word is on o_*.
    checks++; if (first_valid !== 2) begin errors++; $display("FAIL seq_first_valid: got step %0d, expected step 2", first_valid); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (seen_pc.size() <= k) begin
        errors++; $display("FAIL seq_word%0d: got nothing, expected pc %h", k, 32'(k * 4));
      end else if (seen_pc[k] !== 32'(k * 4) || seen_ins[k] !== mem_word(32'(k * 4))) begin
        errors++;
        $display("FAIL seq_word%0d: got pc=%h ins=%h, expected pc=%h ins=%h",
                 k, seen_pc[k], seen_ins[k], 32'(k * 4), mem_word(32'(k * 4)));
      end
    end
  endtask

  task automatic test_stall();
    int          issues;
    logic [31:0] seen[$];
    issues = 0;
    restart();
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      if (obs_req) issues++;
      if (obs_valid) begin
        checks++; if (obs_pc !== 32'h0) begin errors++; $display("FAIL stall_hold_pc: got %h, expected 0", obs_pc); end
      end
    end
    checks++; if (issues !== 2) begin errors++; $display("FAIL stall_issues: got %0d, expected 2", issues); end
    checks++; if (obs_valid !== 1'b1 || obs_req !== 1'b0) begin errors++; $display("FAIL stall_end: got v=%b req=%b, expected v=1 req=0", obs_valid, obs_req); end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      if (obs_valid) seen.push_back(obs_pc);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (seen.size() <= k || seen[k] !== 32'(k * 4)) begin
        errors++; $display("FAIL stall_resume%0d: got %h, expected %h", k, (seen.size() > k) ? seen[k] : 32'hx, 32'(k * 4));
      end
    end
  endtask

  task automatic test_redirect_inflight();
    logic [31:0] seen[$];
    restart();
    lat_lo = 3; lat_hi = 3;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h100, 1'b1);
    checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL redir_req_low: got %b, expected 0", obs_req); end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      if (obs_valid) seen.push_back(obs_pc);
      checks++;
      if (obs_valid !== exp_valid || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
        errors++;
        $display("FAIL redir_out cyc %0d: got v=%b pc=%h, expected v=%b pc=%h", i, obs_valid, obs_pc, exp_valid, exp_pc);
      end
    end
    checks++; if (seen.size() < 2 || seen[0] !== 32'h100 || seen[1] !== 32'h104) begin
      errors++; $display("FAIL redir_first_pcs: got %0d words first %h, expected 00000100 then 00000104",
                         seen.size(), (seen.size() > 0) ? seen[0] : 32'hx);
    end
  endtask

  task automatic test_redirect_with_rvalid();
    int n;
    restart();
    lat_lo = 1; lat_hi = 1;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h40, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL rr_dropped: got v=%b pc=%h, expected v=0", obs_valid, obs_pc); end
    n = 0;
    while (!obs_valid && n < 10) begin step(1'b0, 1'b0, 32'h0, 1'b1); n++; end
    checks++; if (obs_valid !== 1'b1 || obs_pc !== 32'h40 || obs_instr !== mem_word(32'h40)) begin
      errors++; $display("FAIL rr_resume: got v=%b pc=%h ins=%h, expected v=1 pc=00000040 ins=%h", obs_valid, obs_pc, obs_instr, mem_word(32'h40));
    end
    // Flush while ID is stalled.
    step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h81, 1'b1);
    checks++; if (obs_valid !== 1'b1) begin errors++; $display("FAIL rs_before: got v=%b, expected 1", obs_valid); end
    step(1'b1, 1'b0, 32'h0, 1'b1);
    checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL rs_flush: got v=%b pc=%h, expected v=0", obs_valid, obs_pc); end
    n = 0;
    while (!obs_valid && n < 10) begin step(1'b0, 1'b0, 32'h0, 1'b1); n++; end
    checks++; if (obs_valid !== 1'b1 || obs_pc !== 32'h80 || obs_instr !== mem_word(32'h80)) begin
      errors++; $display("FAIL rs_resume: got v=%b pc=%h, expected v=1 pc=00000080", obs_valid, obs_pc);
    end
  endtask

  task automatic test_gnt_wait();
    int n;
    restart();
    lat_lo = 1; lat_hi = 1;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    n = 0;
    while (!(obs_req && obs_addr == 32'h8) && n < 8) begin step(1'b0, 1'b0, 32'h0, 1'b0); n++; end
    checks++; if (n >= 8) begin errors++; $display("FAIL gw_req: got req=%b addr=%h, expected req=1 addr=00000008", obs_req, obs_addr); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h8) begin
        errors++; $display("FAIL gw_stable%0d: got req=%b addr=%h, expected req=1 addr=00000008", i, obs_req, obs_addr);
      end
    end
    step(1'b0, 1'b1, 32'h203, 1'b0);
    checks++; if (obs_req !== 1'b0) begin errors++; $display("FAIL gw_redir_req: got %b, expected 0", obs_req); end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    checks++; if (obs_req !== 1'b1 || obs_addr !== 32'h200) begin
      errors++; $display("FAIL gw_new_addr: got req=%b addr=%h, expected req=1 addr=00000200", obs_req, obs_addr);
    end
    n = 0;
    while (!obs_valid && n < 10) begin step(1'b0, 1'b0, 32'h0, 1'b1); n++; end
    checks++; if (obs_valid !== 1'b1 || obs_pc !== 32'h200 || obs_instr !== mem_word(32'h200)) begin
      errors++; $display("FAIL gw_word: got v=%b pc=%h, expected v=1 pc=00000200", obs_valid, obs_pc);
    end
  endtask

  task automatic test_random();
    logic        st, rd, g;
    logic [31:0] rpc;
    restart();
    lat_lo = 1; lat_hi = 5;
    for (int i = 0; i < 700; i++) begin
      st = ($urandom_range(99) < 30);
      rd = ($urandom_range(99) < 8);
      g = ($urandom_range(99) < 65);
      rpc = $urandom & 32'h0000_3fff;
      step(st, rd, rpc, g);
      checks++; if (obs_req !== exp_req) begin errors++; $display("FAIL rnd_req cyc %0d: got %b, expected %b", i, obs_req, exp_req); end
      if (exp_req) begin
        checks++; if (obs_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr cyc %0d: got %h, expected %h", i, obs_addr, exp_addr); end
      end
      checks++;
      if (obs_valid !== exp_valid || obs_pc !== exp_pc || obs_instr !== exp_instr) begin
        errors++;
        $display("FAIL rnd_out cyc %0d: got v=%b pc=%h ins=%h, expected v=%b pc=%h ins=%h",
                 i, obs_valid, obs_pc, obs_instr, exp_valid, exp_pc, exp_instr);
      end
      if (i == 350) begin
        #1;
        rst = 1'b1;
        ifc.imem_gnt = 1'b0;
        ifc.imem_rvalid = 1'b0;
        redirect = 1'b0;
        #1;
        checks++;
        if (ifc.imem_req !== 1'b0 || ifc.imem_addr !== RESET_PC || o_valid !== 1'b0 ||
            o_instruction !== NOP || o_pc !== 32'h0) begin
          errors++;
          $display("FAIL async_rst: got req=%b addr=%h v=%b ins=%h pc=%h, expected 0 %h 0 %h 0",
                   ifc.imem_req, ifc.imem_addr, o_valid, o_instruction, o_pc, RESET_PC, NOP);
        end
        clear_model();
        @(negedge clk);
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    ifc.imem_gnt = 1'b0;
    ifc.imem_rvalid = 1'b0;
    ifc.imem_rdata = 32'h0;
    mpc = RESET_PC;
    test_reset();
    test_sequential_fetch();
    test_stall();
    test_redirect_inflight();
    test_redirect_with_rvalid();
    test_gnt_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by t=200000, expected bench to finish");
    $fatal(1, "watchdog expired");
  end
endmodule
